// File: rtl/csa_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 64-bit carry-select adder, one limb per cycle, LSW first.
// Define CSA_SEQ_OVF_EN to add the signed-overflow output ovf.

module csa_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [4:0] c;

    assign c[0] = cin;

    // Each 16-bit block precomputes both carry-in cases; the incoming carry only steers a mux.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [16:0] s0;
        logic [16:0] s1;
        assign s0 = {1'b0, a[g*16 +: 16]} + {1'b0, b[g*16 +: 16]};
        assign s1 = {1'b0, a[g*16 +: 16]} + {1'b0, b[g*16 +: 16]} + 17'd1;
        assign sum[g*16 +: 16] = c[g] ? s1[15:0] : s0[15:0];
        assign c[g+1] = c[g] ? s1[16] : s0[16];
    end

    assign cout = c[4];
endmodule

module csa_mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  op_sub,
    input  logic [64*WORDS-1:0]   a,
    input  logic [64*WORDS-1:0]   b,
    output logic [64*WORDS-1:0]   res,
    output logic                  cout,
`ifdef CSA_SEQ_OVF_EN
    output logic                  ovf,
`endif
    output logic                  res_valid,
    input  logic                  res_ready
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   carry;
    logic                   sub_buf;
    logic [WORDS-1:0][63:0] a_buf;
    logic [WORDS-1:0][63:0] b_buf;
    logic [WORDS-1:0][63:0] res_q;
    logic [63:0]            limb_a;
    logic [63:0]            limb_b;
    logic [63:0]            limb_sum;
    logic                   limb_cout;

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry loaded from op_sub.
    assign limb_a = a_buf[cnt];
    assign limb_b = sub_buf ? ~b_buf[cnt] : b_buf[cnt];

    csa_64 u_add (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (carry),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    assign res = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            sub_buf     <= 1'b0;
            a_buf       <= '0;
            b_buf       <= '0;
            res_q       <= '0;
            cout        <= 1'b0;
            res_valid   <= 1'b0;
            start_ready <= 1'b0;
`ifdef CSA_SEQ_OVF_EN
            ovf         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        a_buf       <= a;
                        b_buf       <= b;
                        sub_buf     <= op_sub;
                        carry       <= op_sub;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    res_q[cnt] <= limb_sum;
                    carry      <= limb_cout;
                    if (cnt == LAST) begin
                        cout      <= limb_cout;
                        res_valid <= 1'b1;
`ifdef CSA_SEQ_OVF_EN
                        ovf       <= (limb_a[63] == limb_b[63]) && (limb_sum[63] != limb_a[63]);
`endif
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_mp_add_seq.sv
// Self-checking bench for csa_mp_add_seq: directed corner cases plus random add/sub against a wide-arithmetic model.
// Exercises ovf as well when CSA_SEQ_OVF_EN is defined.

module tb_csa_mp_add_seq;
    localparam int WORDS = 4;
    localparam int N     = 64 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_valid, start_ready, op_sub, cout, res_valid, res_ready;
    logic [N-1:0]   a, b, res;
    logic           start_valid1, start_ready1, op_sub1, cout1, res_valid1, res_ready1;
    logic [63:0]    a1, b1, res1;
`ifdef CSA_SEQ_OVF_EN
    logic           ovf, ovf1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_mp_add_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_sub(op_sub), .a(a), .b(b), .res(res), .cout(cout),
`ifdef CSA_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .res_valid(res_valid), .res_ready(res_ready)
    );

    csa_mp_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid1), .start_ready(start_ready1),
        .op_sub(op_sub1), .a(a1), .b(b1), .res(res1), .cout(cout1),
`ifdef CSA_SEQ_OVF_EN
        .ovf(ovf1),
`endif
        .res_valid(res_valid1), .res_ready(res_ready1)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, result} of the full-width operation; for subtraction cout means a >= b.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic sub);
        if (sub) return {x >= y, x - y};
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic model_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic sub);
        logic [N-1:0] r;
        r = sub ? x - y : x + y;
        if (sub) return (x[N-1] != y[N-1]) && (r[N-1] != x[N-1]);
        return (x[N-1] == y[N-1]) && (r[N-1] != x[N-1]);
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N / 32; i++) v = {v[N-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tv, input logic sub, input int hold);
        logic [N:0] exp;
        int cyc;
        exp = model(ta, tv, sub);
        cyc = 0;
        while (!start_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("start_ready_wait", start_ready, 1);
        a = ta; b = tv; op_sub = sub; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0; a = rand_wide(); b = rand_wide(); op_sub = ~sub;
        check("busy_ready", start_ready, 0);
        wait_result(cyc);
        check("latency", cyc, WORDS);
        check("res", res, exp[N-1:0]);
        check("cout", cout, exp[N]);
`ifdef CSA_SEQ_OVF_EN
        check("ovf", ovf, model_ovf(ta, tv, sub));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_res", res, exp[N-1:0]);
            check("hold_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_clear", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N-1:0] xa, xb, pa, pb, ones, msb;
        logic [N:0]   xexp;
        int           cyc;

        ones = '1;
        msb  = '0;
        msb[N-1] = 1'b1;
        rst_n = 1'b0; start_valid = 0; op_sub = 0; a = '0; b = '0; res_ready = 0;
        start_valid1 = 0; op_sub1 = 0; a1 = '0; b1 = '0; res_ready1 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_start_ready", start_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res", res, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        #1 check("rel_start_ready_low", start_ready, 0);
        @(negedge clk);
        check("rel_start_ready_high", start_ready, 1);

        // Full carry ripple and borrow cases
        run_op(ones, 1, 1'b0, 0);
        xa = '0; xa[64] = 1'b1;
        run_op(xa, 1, 1'b1, 0);
        run_op(0, 1, 1'b1, 0);

        // Back-pressure with a second request held pending
        xa = rand_wide(); xb = rand_wide(); pa = rand_wide(); pb = rand_wide();
        xexp = model(xa, xb, 1'b0);
        a = xa; b = xb; op_sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        a = pa; b = pb; op_sub = 1'b1;
        wait_result(cyc);
        check("bp_latency", cyc, WORDS);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res", res, xexp[N-1:0]);
            check("bp_cout", cout, xexp[N]);
            check("bp_start_ready", start_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_valid_clear", res_valid, 0);
        check("bp_ready_back", start_ready, 1);
        run_op(pa, pb, 1'b1, 0);

        // Abort mid-RUN
        a = rand_wide(); b = rand_wide(); op_sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", res_valid, 0);
        check("abort_res", res, 0);
        check("abort_start_ready", start_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(5, 7, 1'b0, 0);

        // Signed-overflow corners
        run_op(ones >> 1, 1, 1'b0, 0);
        run_op(msb, 1, 1'b1, 0);
        run_op(3, 4, 1'b0, 0);

        // Random traffic with random consumer delay
        for (int i = 0; i < 20; i++)
            run_op(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

        // Single-limb instance
        a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'd1; op_sub1 = 1'b0; start_valid1 = 1'b1;
        check("w1_start_ready", start_ready1, 1);
        @(negedge clk);
        start_valid1 = 1'b0;
        check("w1_not_yet", res_valid1, 0);
        @(negedge clk);
        check("w1_valid", res_valid1, 1);
        check("w1_res", res1, 0);
        check("w1_cout", cout1, 1);
`ifdef CSA_SEQ_OVF_EN
        check("w1_ovf", ovf1, 0);
`endif
        res_ready1 = 1'b1;
        @(negedge clk);
        res_ready1 = 1'b0;
        check("w1_valid_clear", res_valid1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
